// File: rtl/spram_2port_arbiter.sv
// spram_2port_arbiter: lets two requesters, A and B, share one single-port
// synchronous RAM. The RAM has a one-cycle registered read.
// Requesters are served round-robin, one access per cycle.
// After reset, an optional sweep writes zero to every RAM word.
module spram_2port_arbiter #(
    parameter int AWIDTH         = 12,
    parameter int DWIDTH         = 60,
    parameter int NUM_WORDS      = 4096,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_wr,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DWIDTH-1:0] a_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_wr,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] b_rdata,
    output logic [AWIDTH-1:0] ram_address,
    output logic              ram_wren,
    output logic [DWIDTH-1:0] ram_data,
    input  logic [DWIDTH-1:0] ram_out,
    output logic              init_done
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic              rr_last_q, rr_last_d;      // 1 = B was granted last
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [AWIDTH-1:0] last_addr_q, last_addr_d;
    logic              grant_a, grant_b;

    // Next state, combinational grant and RAM drive; reset overrides the RAM side and the readies
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        rr_last_d   = rr_last_q;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        ram_wren    = 1'b0;
        ram_address = last_addr_q;
        ram_data    = '0;

        unique case (state_q)
            CLEAR: begin
                ram_wren    = 1'b1;
                ram_address = clr_cnt_q;
                clr_cnt_d   = clr_cnt_q + AWIDTH'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                grant_a = a_valid && (!b_valid || rr_last_q);
                grant_b = b_valid && !grant_a;
                if (grant_a) begin
                    ram_address = a_addr;
                    ram_wren    = a_wr;
                    ram_data    = a_wdata;
                    a_rvalid_d  = !a_wr;
                    rr_last_d   = 1'b0;
                end else if (grant_b) begin
                    ram_address = b_addr;
                    ram_wren    = b_wr;
                    ram_data    = b_wdata;
                    b_rvalid_d  = !b_wr;
                    rr_last_d   = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (reset) begin
            grant_a     = 1'b0;
            grant_b     = 1'b0;
            ram_wren    = 1'b0;
            ram_address = '0;
        end

        last_addr_d = ram_address;
    end

    // State register with synchronous reset; restarts the sweep and drops in-flight responses
    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                state_q <= CLEAR;
            end else begin
                state_q <= RUN;
            end
            clr_cnt_q   <= '0;
            init_done_q <= !CLEAR_ON_RESET;
            rr_last_q   <= 1'b1;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rr_last_q   <= rr_last_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = ram_out;
    assign b_rdata   = ram_out;
    assign init_done = init_done_q;

endmodule
